// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/mul_sign_mag.sv
// Splits an operand into magnitude and sign; in unsigned mode the value passes through.
module mul_sign_mag #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] value,
    input  logic             signed_mode,
    output logic [WIDTH-1:0] magnitude,
    output logic             sign
);

    assign sign      = signed_mode & value[WIDTH-1];
    // The most-negative value negates to itself, which read unsigned is 2^(WIDTH-1).
    assign magnitude = sign ? -value : value;

endmodule

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per clock, signed via sign-magnitude.
module seq_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      out_q, out_d;
    logic               out_valid_q, out_valid_d;

    logic               signed_mode;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_sign, b_sign;
    logic [WIDTH-1:0]   b_shift;
    logic [PW-1:0]      addend;
    logic [PW-1:0]      acc_sum;

    assign signed_mode = (sel == MODE_SIGNED);

    mul_sign_mag #(.WIDTH(WIDTH)) u_mag_a (
        .value       (a),
        .signed_mode (signed_mode),
        .magnitude   (a_mag),
        .sign        (a_sign)
    );

    mul_sign_mag #(.WIDTH(WIDTH)) u_mag_b (
        .value       (b),
        .signed_mode (signed_mode),
        .magnitude   (b_mag),
        .sign        (b_sign)
    );

    always_comb begin
        state_d     = state_q;
        a_mag_d     = a_mag_q;
        b_mag_d     = b_mag_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        // Shifting instead of bit-indexing keeps the select in range for any WIDTH.
        b_shift = b_mag_q >> cnt_q;
        addend  = b_shift[0] ? ({{WIDTH{1'b0}}, a_mag_q} << cnt_q) : '0;
        acc_sum = acc_q + addend;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_mag_d = a_mag;
                    b_mag_d = b_mag;
                    neg_d   = a_sign ^ b_sign;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    out_d       = neg_q ? -acc_sum : acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_mag_q     <= a_mag_d;
            b_mag_q     <= b_mag_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_mul.sv
// Directed and randomised checks of seq_mul at WIDTH=6 and WIDTH=8 against an arithmetic model.
module tb_seq_mul;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    logic        start6, sel6, out_ready6, in_ready6, out_valid6, busy6;
    logic [5:0]  a6, b6;
    logic [11:0] out6;

    logic        start8, sel8, out_ready8, in_ready8, out_valid8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;

    int n_vec    = 0;
    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .in_ready(in_ready6),
        .a(a6), .b(b6), .sel(sel6), .out_valid(out_valid6),
        .out_ready(out_ready6), .out(out6), .busy(busy6)
    );

    seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sel(sel8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out(out8), .busy(busy8)
    );

    // Reference: interpret operands as w-bit integers and multiply exactly.
    function automatic logic [15:0] ref_mul(int w, logic s, logic [7:0] a, logic [7:0] b);
        longint x, y, p;
        x = longint'(a) & ((64'sd1 <<< w) - 1);
        y = longint'(b) & ((64'sd1 <<< w) - 1);
        if (s && a[w-1]) x = x - (64'sd1 <<< w);
        if (s && b[w-1]) y = y - (64'sd1 <<< w);
        p = x * y;
        return 16'(p & ((64'sd1 <<< (2 * w)) - 1));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(int w, logic st, logic [7:0] a, logic [7:0] b, logic s, logic ordy);
        if (w == 6) begin
            start6 = st; a6 = a[5:0]; b6 = b[5:0]; sel6 = s; out_ready6 = ordy;
        end else begin
            start8 = st; a8 = a; b8 = b; sel8 = s; out_ready8 = ordy;
        end
    endtask

    function automatic logic get_valid(int w);
        return (w == 6) ? out_valid6 : out_valid8;
    endfunction

    function automatic logic get_in_ready(int w);
        return (w == 6) ? in_ready6 : in_ready8;
    endfunction

    function automatic logic get_busy(int w);
        return (w == 6) ? busy6 : busy8;
    endfunction

    function automatic logic [15:0] get_out(int w);
        return (w == 6) ? {4'h0, out6} : out8;
    endfunction

    // One full transaction; with hold set the consumer stalls 10 cycles while start is pulsed.
    task automatic do_op(int w, logic s, logic [7:0] a, logic [7:0] b,
                         logic [15:0] exp, string tag, bit hold);
        int lat;
        check({tag, "_in_ready"}, 32'(get_in_ready(w)), 32'd1);
        drive(w, 1'b1, a, b, s, 1'b0);
        step();
        drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        lat = 0;
        while (!get_valid(w) && lat < 40) begin
            check({tag, "_in_ready_busy"}, 32'(get_in_ready(w)), 32'd0);
            check({tag, "_busy"}, 32'(get_busy(w)), 32'd1);
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(w));
        check({tag, "_out"}, 32'(get_out(w)), 32'(exp));
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                drive(w, 1'(k), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
                step();
                check({tag, "_hold_out"}, 32'(get_out(w)), 32'(exp));
                check({tag, "_hold_valid"}, 32'(get_valid(w)), 32'd1);
                check({tag, "_hold_busy"}, 32'(get_busy(w)), 32'd0);
            end
        end
        drive(w, hold, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        step();
        drive(w, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check({tag, "_valid_drop"}, 32'(get_valid(w)), 32'd0);
        check({tag, "_idle_in_ready"}, 32'(get_in_ready(w)), 32'd1);
        check({tag, "_out_retained"}, 32'(get_out(w)), 32'(exp));
        if (hold) begin
            step();
            check({tag, "_start_ignored"}, 32'(get_busy(w)), 32'd0);
            check({tag, "_still_idle"}, 32'(get_in_ready(w)), 32'd1);
        end
        n_vec++;
    endtask

    initial begin
        int w;
        logic s;
        logic [7:0] ra, rb;

        rst_n = 1'b0;
        drive(6, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out6", 32'(out6), 32'd0);
        check("rst_valid6", 32'(out_valid6), 32'd0);
        check("rst_busy6", 32'(busy6), 32'd0);
        check("rst_in_ready6", 32'(in_ready6), 32'd1);
        check("rst_out8", 32'(out8), 32'd0);
        check("rst_valid8", 32'(out_valid8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        do_op(6, MODE_SIGNED,   8'h3D, 8'h05, 16'h0FF1, "s_m3x5", 1'b0);
        do_op(6, MODE_SIGNED,   8'h20, 8'h20, 16'h0400, "s_min_x_min", 1'b0);
        do_op(6, MODE_SIGNED,   8'h20, 8'h01, 16'h0FE0, "s_min_x_1", 1'b0);
        do_op(6, MODE_UNSIGNED, 8'h3F, 8'h3F, 16'h0F81, "u_63x63", 1'b0);
        do_op(6, MODE_UNSIGNED, 8'h3D, 8'h05, 16'h0131, "u_61x5", 1'b0);
        do_op(6, MODE_SIGNED,   8'h00, 8'h3D, 16'h0000, "s_0xm3", 1'b0);
        do_op(6, MODE_UNSIGNED, 8'h07, 8'h09, 16'h003F, "u_hold", 1'b1);
        do_op(8, MODE_SIGNED,   8'h80, 8'h80, 16'h4000, "s8_min_x_min", 1'b0);
        do_op(8, MODE_UNSIGNED, 8'hFF, 8'hFF, 16'hFE01, "u8_255x255", 1'b0);

        do_op(6, MODE_SIGNED, 8'h3D, 8'h05, 16'h0FF1, "pre_reset", 1'b0);
        drive(6, 1'b1, 8'h0B, 8'h03, MODE_SIGNED, 1'b0);
        step();
        drive(6, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) step();
        check("mid_busy_before_reset", 32'(busy6), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out6), 32'd0);
        check("async_rst_valid", 32'(out_valid6), 32'd0);
        check("async_rst_busy", 32'(busy6), 32'd0);
        check("async_rst_in_ready", 32'(in_ready6), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_op(6, MODE_SIGNED, 8'h07, 8'h3C, 16'h0FE4, "post_reset_7xm4", 1'b0);

        for (int i = 0; i < 1000; i++) begin
            w  = (i < 600) ? 6 : 8;
            s  = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 9) == 0) ra = 8'h00;
            if ($urandom_range(0, 9) == 0) rb = 8'h00;
            do_op(w, s, ra, rb, ref_mul(w, s, ra, rb), "rand", 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mul.md
Name: seq_mul

Overview:
Parametrised iterative shift-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
Mode select chooses signed (two's complement, sign-magnitude internally) or unsigned operation.
Operands arrive via a start/in_ready handshake; one multiplier bit is processed per clock; the result is held under an out_valid/out_ready handshake.
Intended as the area-efficient replacement for combinational multipliers in the datapath.

Parameters:
WIDTH, 6, operand width in bits (>=2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to accept a, b, sel this cycle
in_ready  output  1  high when the block can accept start (IDLE only)
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
sel  input  1  1 = signed two's complement, 0 = unsigned; captured with operands
out_valid  output  1  product available
out_ready  input  1  consumer takes product this cycle
out  output  2*WIDTH  product, two's complement when the captured sel=1
busy  output  1  high in BUSY state

Behaviour:
- Reset (rst_n low, async): state=IDLE, out=0, out_valid=0, busy=0, in_ready=1 after release; internal regs cleared.
- States: IDLE, BUSY, DONE (enum in package).
- IDLE: in_ready=1. On a rising edge with start=1: capture sel; if sel=1, operand magnitudes = |a|, |b| as WIDTH-bit unsigned, and neg = a[MSB] xor b[MSB]; if sel=0, magnitudes = a, b and neg=0. Clear accumulator and count; go to BUSY.
- BUSY: each edge, if b_mag[count]=1, acc += a_mag << count (acc is 2*WIDTH bits, never truncated); count++. When count==WIDTH-1 on an edge: final add, out = neg ? -acc : acc, out_valid=1, state=DONE.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge; a new operation can start 1 cycle after handshake completion, giving a throughput of one per WIDTH+2 cycles minimum.
- DONE: out and out_valid held stable until out_ready=1 on an edge; then out_valid=0, state=IDLE. out retains its last value after the handshake.
- start outside IDLE: ignored, no side effects. start and out_ready together in DONE: only out_ready acts; start must be re-presented in IDLE.
- Inputs a, b, sel may change freely after acceptance; captured values are used.
- Most-negative operand (-2^(WIDTH-1)): magnitude 2^(WIDTH-1) fits WIDTH-bit unsigned; the product is exact. (-32)*(-32)=1024 for WIDTH=6. No bit of the result is cleared or saturated.
- Zero product with neg=1 yields out=0, never a negative zero pattern issue.
- Reset asserted mid-BUSY or in DONE: immediate return to reset values, and the operation is discarded.

Decomposition:
- mul_pkg: state enum (IDLE, BUSY, DONE), mode localparams MODE_UNSIGNED=0, MODE_SIGNED=1.
- Sub-module mul_sign_mag (combinational, parametrised WIDTH): inputs value and signed_mode; outputs magnitude and sign bit. It is instantiated twice for a and b.
- The top-level holds the FSM, counter, accumulator and output register.

Test Plan:
- WIDTH=6, sel=1, a=6'b111101(-3), b=6'b000101(5), start -> out_valid 6 edges later, out=12'hFF1(-15); in_ready low throughout.
- sel=1, a=6'b100000, b=6'b100000 -> out=12'd1024. sel=1, a=6'b100000, b=6'd1 -> out=12'hFE0(-32).
- sel=0, a=6'd63, b=6'd63 -> out=12'd3969; sel=0, a=6'b111101, b=6'd5 -> out=12'd305.
- Hold out_ready=0 for 10 cycles in DONE with start pulsed -> out stable, start ignored, then out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rst_n=0 asynchronously mid-BUSY, count=3 -> out_valid=0, out=0 immediately; the next op after release computes correctly, e.g. sel=1, 7*(-4)=12'hFE4.
- Randomised 1000 ops, both modes, WIDTH=6 and WIDTH=8, compared against a reference model; includes 0 operands -> out=0 with out_valid timing unchanged.
